dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller that answers the pipeline's load/store requests and issues line-sized requests to an off-chip data memory. It replaces the single-cycle data memory at the MEM stage; the CPU side is a zero-wait-on-hit responder, and the memory side is a req/ack initiator. While it is servicing a miss it holds the whole pipeline with `cpu_stall_o`.

## Interface
- `NUM_LINES`, default 32: number of cache lines (power of two); index width `IW = log2(NUM_LINES)`.
- `LINE_BYTES`, default 32: bytes per line; offset width `OW = log2(LINE_BYTES)`, line width `LW = 8*LINE_BYTES`.
- Tag width `TW = 32 - IW - OW` (22 at defaults).

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `cpu_req_i`  in  1  MEM-stage access valid (load or store).
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address, word aligned.
- `cpu_data_i`  in  32  store data.
- `cpu_data_o`  out  32  load data; valid when `cpu_req_i & !cpu_we_i & !cpu_stall_o`.
- `cpu_stall_o`  out  1  freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- `mem_req_o`  out  1  memory transaction request.
- `mem_we_o`  out  1  1 = line write-back, 0 = line fill.
- `mem_addr_o`  out  32  line-aligned address; low OW bits are 0.
- `mem_data_o`  out  LW  write-back line data.
- `mem_data_i`  in  LW  fill line data; sampled in the `mem_ack_i` cycle.
- `mem_ack_i`  in  1  one-cycle completion pulse.

## Operation
- Address split: tag = `[31:IW+OW]`, index = `[IW+OW-1:OW]`, word = `[OW-1:2]`.
- Per-line state: valid, dirty, tag, LW data bits.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
- **IDLE**
  - A hit is `cpu_req_i` with the indexed line valid and its tag equal to the address tag.
  - Read hit: `cpu_data_o` takes the selected word combinationally. `cpu_stall_o = 0`.
  - Write hit: the word is written at the clock edge and dirty is set. `cpu_stall_o = 0`.
  - Miss with the victim line valid and dirty: `cpu_stall_o = 1`, go to WRITEBACK.
  - Any other miss: `cpu_stall_o = 1`, go to ALLOCATE.
  - No request: `cpu_stall_o = 0`, stay in IDLE.
- **WRITEBACK**
  - Outputs: `mem_req_o = 1`, `mem_we_o = 1`, `mem_addr_o = {victim tag, index, 0}`, `mem_data_o` = victim line.
  - On `mem_ack_i`, go to ALLOCATE.
- **ALLOCATE**
  - Outputs: `mem_req_o = 1`, `mem_we_o = 0`, `mem_addr_o = {cpu tag, index, 0}`.
  - On `mem_ack_i`, capture `mem_data_i` and go to REFILL.
- **REFILL**
  - Write the captured line and tag, set valid, clear dirty, return to IDLE.
  - The original request is then serviced as a hit; a store sets dirty in that cycle.
- `cpu_stall_o = 1` in every non-IDLE state.
- The CPU holds `cpu_req_i`, `cpu_we_i`, `cpu_addr_i` and `cpu_data_i` stable while stalled; the controller does not latch them.
- Unaligned addresses are not supported; the low 2 bits are ignored.

## Timing
- Reset values:
  - state = IDLE.
  - All valid and dirty bits = 0.
  - `mem_req_o = 0`, `mem_we_o = 0`, `mem_addr_o = 0`, `mem_data_o = 0`, `cpu_data_o = 0`.
  - `cpu_stall_o = 0` while in reset.
- Hit latency: 0 extra cycles.
- Clean-miss stall cycles: 1 (IDLE detect) + A (ALLOCATE cycles, up to and including ack) + 1 (REFILL). Stall is low in the following IDLE hit cycle.
- Dirty-miss stall cycles: the clean-miss count plus W WRITEBACK cycles.
- Memory handshake rules:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_data_o` are registered outputs.
  - They are held stable from assertion until the `mem_ack_i` cycle.
  - `mem_req_o` drops at least one cycle between WRITEBACK and ALLOCATE.
  - An ack arriving in IDLE or REFILL is ignored.
- Ack in the first request cycle is legal and gives A = 1.
- Reset asserted mid-transaction: FSM returns to IDLE immediately, `mem_req_o` clears asynchronously, and the in-flight line is discarded with valid = 0.
- Index wrap: address 0x400 maps to the same line as 0x000 at defaults; this conflict triggers eviction.

## Structure
- Package `dcache_pkg` holds:
  - the FSM state enum;
  - localparams for IW, OW, TW, LW derived from the defaults;
  - helper functions for tag/index/word extraction.
- One sub-module, `dcache_sram`:
  - tag/valid/dirty and data arrays;
  - asynchronous read, one synchronous write port;
  - word-enable for store hits, full-line write for refill;
  - asynchronous clear of the valid/dirty arrays on `rst_i`.
- The controller (`dcache_ctrl`) holds the FSM, hit compare, word mux and memory-port registers.

## Test plan
- Reset, then load 0x0000_0000 with memory acking after 3 cycles → ALLOCATE for 3 cycles, `cpu_stall_o` high for 5 cycles, then `cpu_data_o` = memory word 0 with no stall.
- Store 0xDEAD_BEEF to 0x0000_0004 after that fill → no stall; an immediate load of 0x0000_0004 returns 0xDEAD_BEEF; the line is dirty.
- Load 0x0000_0400 (same index, new tag) → WRITEBACK with `mem_we_o=1`, `mem_addr_o=0x0000_0000`, word 1 of `mem_data_o` = 0xDEAD_BEEF; then ALLOCATE at 0x0000_0400.
- Memory acks in the first request cycle for a clean miss → exactly 3 stall cycles.
- Drop `rst_i` during ALLOCATE → `mem_req_o` is 0 the same cycle; after release, a load of the same address misses again.
- Store miss to 0x0000_0048 → line filled, then the word is written and dirty set; a later eviction writes that word back.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller state encoding, default geometry and address helpers.
package dcache_pkg;

    localparam int DC_NUM_LINES  = 32;
    localparam int DC_LINE_BYTES = 32;
    localparam int DC_IW         = $clog2(DC_NUM_LINES);
    localparam int DC_OW         = $clog2(DC_LINE_BYTES);
    localparam int DC_TW         = 32 - DC_IW - DC_OW;
    localparam int DC_LW         = 8 * DC_LINE_BYTES;
    localparam int DC_WW         = DC_OW - 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_REFILL    = 2'd3
    } dc_state_e;

    // Byte address viewed as its cache fields at the default geometry.
    typedef struct packed {
        logic [DC_TW-1:0] tag;
        logic [DC_IW-1:0] index;
        logic [DC_WW-1:0] word;
        logic [1:0]       boff;
    } dc_addr_t;

    // Split a byte address into tag / index / word / byte-offset fields.
    function automatic dc_addr_t dc_split(input logic [31:0] addr);
        return dc_addr_t'(addr);
    endfunction

    // Line-aligned address (offset bits forced to zero).
    function automatic logic [31:0] dc_line_addr(input logic [31:0] addr);
        return addr & ~((32'd1 << DC_OW) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage for the direct-mapped cache.
// Asynchronous read, one synchronous write port (word or full line).
module dcache_sram #(
    parameter int NUM_LINES = 32,
    parameter int IW        = 5,
    parameter int TW        = 22,
    parameter int LW        = 256,
    parameter int WW        = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [IW-1:0] index,
    output logic          rd_valid,
    output logic          rd_dirty,
    output logic [TW-1:0] rd_tag,
    output logic [LW-1:0] rd_line,
    input  logic          word_we,
    input  logic [WW-1:0] word_sel,
    input  logic [31:0]   word_data,
    input  logic          line_we,
    input  logic [TW-1:0] line_tag,
    input  logic [LW-1:0] line_data
);

    logic [NUM_LINES-1:0] valid_r;
    logic [NUM_LINES-1:0] dirty_r;
    logic [TW-1:0]        tag_r  [NUM_LINES];
    logic [LW-1:0]        data_r [NUM_LINES];

    assign rd_valid = valid_r[index];
    assign rd_dirty = dirty_r[index];
    assign rd_tag   = tag_r[index];
    assign rd_line  = data_r[index];

    // Line status: cleared by reset, set valid/clean on refill, dirty on store hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r <= {NUM_LINES{1'b0}};
            dirty_r <= {NUM_LINES{1'b0}};
        end else if (line_we) begin
            valid_r[index] <= 1'b1;
            dirty_r[index] <= 1'b0;
        end else if (word_we) begin
            dirty_r[index] <= 1'b1;
        end
    end

    // Tag and data arrays: full-line write on refill, single word on store hit.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_r[index]  <= line_tag;
            data_r[index] <= line_data;
        end else if (word_we) begin
            data_r[index][{word_sel, 5'd0} +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache controller.
// Zero-wait hits on the CPU side; line-sized req/ack transactions on the
// memory side. The pipeline is stalled for the whole miss sequence.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 32,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [31:0]             cpu_addr_i,
    input  logic [31:0]             cpu_data_i,
    output logic [31:0]             cpu_data_o,
    output logic                    cpu_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [8*LINE_BYTES-1:0] mem_data_o,
    input  logic [8*LINE_BYTES-1:0] mem_data_i,
    input  logic                    mem_ack_i
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int OW = $clog2(LINE_BYTES);
    localparam int TW = 32 - IW - OW;
    localparam int LW = 8 * LINE_BYTES;
    localparam int WW = OW - 2;

    dc_state_e     state_r;
    logic          mem_req_r;
    logic          mem_we_r;
    logic [31:0]   mem_addr_r;
    logic [LW-1:0] mem_data_r;
    logic [LW-1:0] fill_r;

    logic [TW-1:0] cpu_tag_s;
    logic [IW-1:0] cpu_index_s;
    logic [WW-1:0] cpu_word_s;
    logic [31:0]   cpu_line_addr_s;
    logic [31:0]   victim_addr_s;

    logic          rd_valid_s;
    logic          rd_dirty_s;
    logic [TW-1:0] rd_tag_s;
    logic [LW-1:0] rd_line_s;
    logic [31:0]   rd_word_s;

    logic          idle_s;
    logic          hit_s;
    logic          miss_s;
    logic          word_we_s;
    logic          line_we_s;
    logic [31:0]   cpu_data_s;
    logic          stall_s;

    // Byte-offset bits carry no information for word-aligned accesses.
    logic          unused_addr_s;

    assign cpu_tag_s       = cpu_addr_i[31:IW+OW];
    assign cpu_index_s     = cpu_addr_i[IW+OW-1:OW];
    assign cpu_word_s      = cpu_addr_i[OW-1:2];
    assign unused_addr_s   = ^cpu_addr_i[1:0];
    assign cpu_line_addr_s = {cpu_tag_s, cpu_index_s, {OW{1'b0}}};
    assign victim_addr_s   = {rd_tag_s, cpu_index_s, {OW{1'b0}}};

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .IW        (IW),
        .TW        (TW),
        .LW        (LW),
        .WW        (WW)
    ) u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .index     (cpu_index_s),
        .rd_valid  (rd_valid_s),
        .rd_dirty  (rd_dirty_s),
        .rd_tag    (rd_tag_s),
        .rd_line   (rd_line_s),
        .word_we   (word_we_s),
        .word_sel  (cpu_word_s),
        .word_data (cpu_data_i),
        .line_we   (line_we_s),
        .line_tag  (cpu_tag_s),
        .line_data (fill_r)
    );

    // Hit compare, store-hit enable, load word mux and pipeline stall.
    always_comb begin
        idle_s    = (state_r == ST_IDLE);
        hit_s     = idle_s & cpu_req_i & rd_valid_s & (rd_tag_s == cpu_tag_s);
        miss_s    = idle_s & cpu_req_i & ~hit_s;
        word_we_s = hit_s & cpu_we_i;
        line_we_s = (state_r == ST_REFILL);
        rd_word_s = rd_line_s[{cpu_word_s, 5'd0} +: 32];
        if (hit_s && !cpu_we_i) begin
            cpu_data_s = rd_word_s;
        end else begin
            cpu_data_s = 32'd0;
        end
        if (!rst_i) begin
            stall_s = 1'b0;
        end else if (!idle_s) begin
            stall_s = 1'b1;
        end else begin
            stall_s = miss_s;
        end
    end

    assign cpu_data_o  = cpu_data_s;
    assign cpu_stall_o = stall_s;

    // Miss FSM with registered memory-port outputs held until ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 32'd0;
            mem_data_r <= {LW{1'b0}};
            fill_r     <= {LW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_s) begin
                        if (rd_valid_s && rd_dirty_s) begin
                            state_r    <= ST_WRITEBACK;
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= 1'b1;
                            mem_addr_r <= victim_addr_s;
                            mem_data_r <= rd_line_s;
                        end else begin
                            state_r    <= ST_ALLOCATE;
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= cpu_line_addr_s;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    // Request drops here so ALLOCATE opens with an idle bus cycle.
                    if (mem_req_r && mem_ack_i) begin
                        state_r   <= ST_ALLOCATE;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                    end
                end
                ST_ALLOCATE: begin
                    if (!mem_req_r) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= cpu_line_addr_s;
                    end else if (mem_ack_i) begin
                        fill_r    <= mem_data_i;
                        mem_req_r <= 1'b0;
                        state_r   <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o  = mem_req_r;
    assign mem_we_o   = mem_we_r;
    assign mem_addr_o = mem_addr_r;
    assign mem_data_o = mem_data_r;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of CPU accesses with expected
// stall counts / load data, plus a scoreboard of expected memory transactions.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int LW = 256;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        int          exp_stalls;
        logic [31:0] exp_rdata;
        logic        exp_wb;
        logic [31:0] wb_addr;
        int          wb_word;
        logic [31:0] wb_val;
        logic        exp_fill;
        logic [31:0] fill_addr;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        int          word;
        logic [31:0] val;
    } exp_txn_t;

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [LW-1:0] line;
    } obs_txn_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          cpu_req_i = 1'b0;
    logic          cpu_we_i = 1'b0;
    logic [31:0]   cpu_addr_i = 32'd0;
    logic [31:0]   cpu_data_i = 32'd0;
    logic [31:0]   cpu_data_o;
    logic          cpu_stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [LW-1:0] mem_data_o;
    logic [LW-1:0] mem_data_i;
    logic          resp_ack;
    logic          stray_ack = 1'b0;
    logic          mem_ack_i;

    int            ack_delay = 1;
    int            checks = 0;
    int            failures = 0;
    exp_txn_t      exp_q[$];
    obs_txn_t      obs_q[$];
    logic [31:0]   mem_words [1024];
    vec_t          vecs [12];

    assign mem_ack_i = resp_ack | stray_ack;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    // Memory responder: acks after ack_delay request cycles, records each transaction.
    initial begin
        int cnt;
        int base;
        obs_txn_t o;
        logic [LW-1:0] line;
        for (int i = 0; i < 1024; i++) mem_words[i] = {16'hC0DE, 16'(i * 4)};
        resp_ack = 1'b0;
        mem_data_i = '0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (resp_ack) begin
                resp_ack = 1'b0;
                cnt = 0;
            end else if (mem_req_o) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    base = int'(mem_addr_o[11:2]);
                    o.we = mem_we_o;
                    o.addr = mem_addr_o;
                    o.line = mem_data_o;
                    if (mem_we_o) begin
                        for (int w = 0; w < 8; w++) mem_words[base + w] = mem_data_o[w*32 +: 32];
                    end else begin
                        for (int w = 0; w < 8; w++) line[w*32 +: 32] = mem_words[base + w];
                        mem_data_i = line;
                    end
                    obs_q.push_back(o);
                    resp_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input int delay, output int stalls, output logic [31:0] rdata);
        ack_delay = delay;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b1;
        cpu_we_i = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        stalls = 0;
        @(negedge clk);
        while (cpu_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        rdata = cpu_data_o;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int stalls;
        logic [31:0] rdata;
        exp_txn_t e;
        obs_txn_t o;
        if (v.exp_wb) begin
            e.we = 1'b1; e.addr = v.wb_addr; e.word = v.wb_word; e.val = v.wb_val;
            exp_q.push_back(e);
        end
        if (v.exp_fill) begin
            e.we = 1'b0; e.addr = v.fill_addr; e.word = 0; e.val = 32'd0;
            exp_q.push_back(e);
        end
        access(v.we, v.addr, v.wdata, v.delay, stalls, rdata);
        check({name, "_stalls"}, 32'(stalls), 32'(v.exp_stalls));
        if (!v.we) check({name, "_rdata"}, rdata, v.exp_rdata);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL %s_txn_missing actual=none expected_addr=0x%08h", name, e.addr);
            end else begin
                o = obs_q.pop_front();
                check({name, "_txn_we"}, 32'(o.we), 32'(e.we));
                check({name, "_txn_addr"}, o.addr, e.addr);
                if (e.we) check({name, "_wb_word"}, o.line[e.word*32 +: 32], e.val);
            end
        end
        check({name, "_txn_extra"}, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    initial begin
        vec_t hv;
        dc_addr_t sa;
        // we addr wdata delay stalls rdata | wb wb_addr word val | fill fill_addr
        vecs[0]  = '{1'b0, 32'h000, 32'h0,         3, 5, 32'hC0DE0000, 1'b0, 32'h0,   0, 32'h0,         1'b1, 32'h000};
        vecs[1]  = '{1'b1, 32'h004, 32'hDEADBEEF,  1, 0, 32'h0,        1'b0, 32'h0,   0, 32'h0,         1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h004, 32'h0,         1, 0, 32'hDEADBEEF, 1'b0, 32'h0,   0, 32'h0,         1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h400, 32'h0,         2, 7, 32'hC0DE0400, 1'b1, 32'h000, 1, 32'hDEADBEEF,  1'b1, 32'h400};
        vecs[4]  = '{1'b0, 32'h004, 32'h0,         1, 3, 32'hDEADBEEF, 1'b0, 32'h0,   0, 32'h0,         1'b1, 32'h000};
        vecs[5]  = '{1'b0, 32'h008, 32'h0,         1, 0, 32'hC0DE0008, 1'b0, 32'h0,   0, 32'h0,         1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h048, 32'h12345678,  1, 3, 32'h0,        1'b0, 32'h0,   0, 32'h0,         1'b1, 32'h040};
        vecs[7]  = '{1'b0, 32'h048, 32'h0,         1, 0, 32'h12345678, 1'b0, 32'h0,   0, 32'h0,         1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h040, 32'h0,         1, 0, 32'hC0DE0040, 1'b0, 32'h0,   0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h448, 32'h0,         1, 5, 32'hC0DE0448, 1'b1, 32'h040, 2, 32'h12345678,  1'b1, 32'h440};
        vecs[10] = '{1'b0, 32'h3E0, 32'h0,         4, 6, 32'hC0DE03E0, 1'b0, 32'h0,   0, 32'h0,         1'b1, 32'h3E0};
        vecs[11] = '{1'b0, 32'h7E4, 32'h0,         1, 3, 32'hC0DE07E4, 1'b0, 32'h0,   0, 32'h0,         1'b1, 32'h7E0};

        // Reset state, with a request presented during reset.
        cpu_req_i = 1'b1;
        cpu_addr_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_data_or", 32'(|mem_data_o), 32'd0);
        check("rst_cpu_stall", 32'(cpu_stall_o), 32'd0);
        check("rst_cpu_data", cpu_data_o, 32'd0);
        cpu_req_i = 1'b0;
        rst_i = 1'b1;

        for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset dropped while a fill is outstanding.
        ack_delay = 50;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b1;
        cpu_we_i = 1'b0;
        cpu_addr_i = 32'h800;
        repeat (3) @(negedge clk);
        check("alloc_req", 32'(mem_req_o), 32'd1);
        check("alloc_we", 32'(mem_we_o), 32'd0);
        check("alloc_addr", mem_addr_o, 32'h800);
        check("alloc_stall", 32'(cpu_stall_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst_req_async", 32'(mem_req_o), 32'd0);
        check("midrst_stall", 32'(cpu_stall_o), 32'd0);
        cpu_req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        check("postrst_req", 32'(mem_req_o), 32'd0);
        obs_q.delete();

        // Same address misses again after reset.
        sa = dc_split(32'h804);
        hv = '{1'b0, 32'h800, 32'h0, 1, 3, 32'hC0DE0800, 1'b0, 32'h0, 0, 32'h0,
               1'b1, dc_line_addr({sa.tag, sa.index, sa.word, sa.boff})};
        run_vec("rerun_800", hv);

        // Stray ack while idle must be ignored.
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_req", 32'(mem_req_o), 32'd0);
        check("stray_stall", 32'(cpu_stall_o), 32'd0);
        hv = '{1'b0, 32'h800, 32'h0, 1, 0, 32'hC0DE0800, 1'b0, 32'h0, 0, 32'h0, 1'b0, 32'h0};
        run_vec("stray_hit", hv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
